// File: rtl/memory_stage.sv
// Y86-64 data-memory stage: one byte per cycle over an 8-cycle ACCESS phase, little-endian.
// Define DMEM_ALIGN_CHECK_EN to also treat addresses that are not 8-byte aligned as faults.
module memory_stage #(
  parameter int MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  icode,
  input  logic [63:0] valE,
  input  logic [63:0] valA,
  input  logic [63:0] valP,
  output logic [63:0] valM,
  output logic        done,
  output logic        busy,
  output logic        dmem_error
);

  localparam int          AW        = (MEM_BYTES > 8) ? $clog2(MEM_BYTES) : 3;
  localparam logic [63:0] LAST_BASE = 64'(MEM_BYTES - 8);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  logic [1:0]    state;
  logic [2:0]    byte_cnt;
  logic          is_write;
  logic [AW-1:0] base;
  logic [AW-1:0] byte_addr;
  logic [63:0]   wdata;
  logic [55:0]   rdata;
  logic [7:0]    mem [MEM_BYTES];

  logic          req_read;
  logic          req_write;
  logic          fault;
  logic [63:0]   req_addr;
  logic [63:0]   req_data;
  logic [64:0]   req_end;

  always_comb begin
    req_read  = 1'b0;
    req_write = 1'b0;
    req_addr  = valE;
    req_data  = valA;
    case (icode)
      4'h4, 4'hA: req_write = 1'b1;
      4'h8: begin
        req_write = 1'b1;
        req_data  = valP;
      end
      4'h5: req_read = 1'b1;
      4'h9, 4'hB: begin
        req_read = 1'b1;
        req_addr = valA;
      end
      default: ;
    endcase
  end

  // A request faults if any of its eight bytes falls outside memory or the end address wraps.
  always_comb begin
    req_end = {1'b0, req_addr} + 65'd7;
    fault   = req_end[64] || (req_addr > LAST_BASE);
`ifdef DMEM_ALIGN_CHECK_EN
    if (req_addr[2:0] != 3'd0) fault = 1'b1;
`else
    fault = fault;
`endif
  end

  assign byte_addr  = base + AW'(byte_cnt);
  assign done       = (state == DONE);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      byte_cnt   <= 3'd0;
      is_write   <= 1'b0;
      base       <= '0;
      wdata      <= 64'd0;
      rdata      <= 56'd0;
      valM       <= 64'd0;
      dmem_error <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            byte_cnt <= 3'd0;
            is_write <= req_write;
            base     <= req_addr[AW-1:0];
            wdata    <= req_data;
            if ((req_read || req_write) && !fault) begin
              state <= ACCESS;
            end else begin
              state      <= DONE;
              valM       <= 64'd0;
              dmem_error <= fault && (req_read || req_write);
            end
          end
        end
        ACCESS: begin
          byte_cnt <= byte_cnt + 3'd1;
          wdata    <= {8'h00, wdata[63:8]};
          rdata    <= {mem[byte_addr], rdata[55:8]};
          if (byte_cnt == 3'd7) begin
            state      <= DONE;
            valM       <= is_write ? 64'd0 : {mem[byte_addr], rdata};
            dmem_error <= 1'b0;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Memory is deliberately left out of reset so bytes committed before an abort survive.
  always_ff @(posedge clk) begin
    if (!reset && state == ACCESS && is_write) begin
      mem[byte_addr] <= wdata[7:0];
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: table-driven vectors with a scoreboard queue,
// plus hand-written busy, done-cycle and reset-abort sequences.
module tb_memory_stage;

  localparam int MEM_BYTES = 1024;
  localparam int NV        = 14;
  localparam int MAX_WAIT  = 20;

  typedef struct {
    string       name;
    logic [3:0]  icode;
    logic [63:0] val_e;
    logic [63:0] val_a;
    logic [63:0] val_p;
    logic [63:0] exp_m;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  icode;
  logic [63:0] valE;
  logic [63:0] valA;
  logic [63:0] valP;
  logic [63:0] valM;
  logic        done;
  logic        busy;
  logic        dmem_error;

  int   errors;
  int   checks;
  vec_t vecs [NV];
  vec_t exp_q [$];

  memory_stage #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .icode      (icode),
    .valE       (valE),
    .valA       (valA),
    .valP       (valP),
    .valM       (valM),
    .done       (done),
    .busy       (busy),
    .dmem_error (dmem_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(string n, logic [3:0] ic, logic [63:0] e, logic [63:0] a,
                              logic [63:0] p, logic [63:0] m, logic err, int lat);
    vec_t v;
    v.name = n; v.icode = ic; v.val_e = e; v.val_a = a; v.val_p = p;
    v.exp_m = m; v.exp_err = err; v.exp_lat = lat;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pops the expected record for the completed request; edges counts the start edge as 1.
  task automatic checkOutput(input int edges);
    vec_t e;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      check({e.name, "_done_seen"}, 64'(done), 64'd1);
      check({e.name, "_latency"}, 64'(edges), 64'(e.exp_lat));
      check({e.name, "_valM"}, valM, e.exp_m);
      check({e.name, "_err"}, 64'(dmem_error), 64'(e.exp_err));
    end
    tick();
    check({e.name, "_idle_after"}, {62'd0, busy, done}, 64'd0);
  endtask

  task automatic applyStimulus(input vec_t v);
    int edges;
    icode = v.icode;
    valE  = v.val_e;
    valA  = v.val_a;
    valP  = v.val_p;
    start = 1'b1;
    exp_q.push_back(v);
    tick();
    start = 1'b0;
    edges = 1;
    while (!done && edges < MAX_WAIT) begin
      tick();
      edges++;
    end
    checkOutput(edges);
  endtask

  initial begin
    int   edges;
    int   done_cnt;
    int   first_done;
    errors = 0;
    checks = 0;
    reset  = 1'b1;
    start  = 1'b0;
    icode  = 4'h0;
    valE   = 64'd0;
    valA   = 64'd0;
    valP   = 64'd0;

    vecs[0]  = mk("wr_40",     4'h4, 64'h40, 64'h1122334455667788, 64'd0, 64'd0, 1'b0, 9);
    vecs[1]  = mk("rd_40",     4'h5, 64'h40, 64'd0, 64'd0, 64'h1122334455667788, 1'b0, 9);
    vecs[2]  = mk("call_100",  4'h8, 64'h100, 64'hFFFF, 64'h2A, 64'd0, 1'b0, 9);
    vecs[3]  = mk("ret_100",   4'h9, 64'h40, 64'h100, 64'd0, 64'h2A, 1'b0, 9);
    vecs[4]  = mk("wr_top",    4'h4, 64'(MEM_BYTES - 8), 64'hCAFEF00D12345678, 64'd0, 64'd0, 1'b0, 9);
    vecs[5]  = mk("rd_oob",    4'h5, 64'(MEM_BYTES - 7), 64'd0, 64'd0, 64'd0, 1'b1, 1);
    vecs[6]  = mk("wr_wrap",   4'h4, 64'hFFFFFFFFFFFFFFFC, 64'd0, 64'd0, 64'd0, 1'b1, 1);
    vecs[7]  = mk("rd_top",    4'h5, 64'(MEM_BYTES - 8), 64'd0, 64'd0, 64'hCAFEF00D12345678, 1'b0, 9);
    vecs[8]  = mk("nop_6",     4'h6, 64'h40, 64'h40, 64'd0, 64'd0, 1'b0, 1);
    vecs[9]  = mk("push_48",   4'hA, 64'h48, 64'h0807060504030299, 64'd0, 64'd0, 1'b0, 9);
    vecs[10] = mk("pop_48",    4'hB, 64'd0, 64'h48, 64'd0, 64'h0807060504030299, 1'b0, 9);
`ifdef DMEM_ALIGN_CHECK_EN
    vecs[11] = mk("rd_41",     4'h5, 64'h41, 64'd0, 64'd0, 64'd0, 1'b1, 1);
`else
    vecs[11] = mk("rd_41",     4'h5, 64'h41, 64'd0, 64'd0, 64'h9911223344556677, 1'b0, 9);
`endif
    vecs[12] = mk("rd_40_again", 4'h5, 64'h40, 64'd0, 64'd0, 64'h1122334455667788, 1'b0, 9);
    vecs[13] = mk("halt_0",    4'h0, 64'd0, 64'd0, 64'd0, 64'd0, 1'b0, 1);

    tick();
    tick();
    check("reset_outputs", {valM[61:0], done, busy}, 64'd0);
    check("reset_err", 64'(dmem_error), 64'd0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < NV; i++) begin
      applyStimulus(vecs[i]);
    end

    check("mem_40", 64'(dut.mem[64]), 64'h88);
    check("mem_47", 64'(dut.mem[71]), 64'h11);

    // Second start arrives mid-ACCESS with different inputs; only one done and the data is untouched.
    icode = 4'h4; valE = 64'h200; valA = 64'hA5A5A5A5A5A5A5A5; start = 1'b1;
    tick();
    start = 1'b0;
    edges = 1;
    check("busy_in_access", 64'(busy), 64'd1);
    tick(); tick();
    edges += 2;
    icode = 4'h5; valE = 64'h40; valA = 64'd0; start = 1'b1;
    tick();
    start = 1'b0;
    edges++;
    done_cnt   = 0;
    first_done = 0;
    if (done) begin done_cnt++; first_done = edges; end
    while (edges < 24) begin
      tick();
      edges++;
      if (done) begin
        done_cnt++;
        if (first_done == 0) first_done = edges;
      end
    end
    check("busy_ignore_done_count", 64'(done_cnt), 64'd1);
    check("busy_ignore_latency", 64'(first_done), 64'd9);
    applyStimulus(mk("rd_200", 4'h5, 64'h200, 64'd0, 64'd0, 64'hA5A5A5A5A5A5A5A5, 1'b0, 9));

    // start held through the DONE cycle must not launch another request.
    icode = 4'h6; start = 1'b1;
    tick();
    check("done_cycle_done", 64'(done), 64'd1);
    tick();
    start = 1'b0;
    check("done_cycle_idle", {62'd0, busy, done}, 64'd0);
    tick();
    check("done_cycle_no_second", {62'd0, busy, done}, 64'd0);

    // Reset during ACCESS cycle 3 of a write leaves bytes 0..2 committed and the rest intact.
    applyStimulus(mk("wr_80", 4'h4, 64'h80, 64'h0123456789ABCDEF, 64'd0, 64'd0, 1'b0, 9));
    applyStimulus(mk("rd_80", 4'h5, 64'h80, 64'd0, 64'd0, 64'h0123456789ABCDEF, 1'b0, 9));
    icode = 4'hA; valE = 64'h80; valA = 64'hFFFFFFFFFFFFFFFF; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    check("abort_valM", valM, 64'd0);
    check("abort_flags", {61'd0, done, busy, dmem_error}, 64'd0);
    reset = 1'b0;
    tick();
    check("abort_idle", {62'd0, busy, done}, 64'd0);
    check("abort_mem_82", 64'(dut.mem[130]), 64'hFF);
    check("abort_mem_83", 64'(dut.mem[131]), 64'h89);
    applyStimulus(mk("rd_80_abort", 4'h5, 64'h80, 64'd0, 64'd0, 64'h0123456789FFFFFF, 1'b0, 9));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
